// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB,
    WAIT_ACK,
    WAIT_DONE
  } sched_state_t;

  localparam int unsigned UART_DATA_W      = 8;
  localparam int unsigned UART_ACK_TIMEOUT = 512;

  // Round-robin successor of idx in 0..n-1.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester byte streams plus transmitter handshake shared by the scheduler and its environment.
interface uart_tx_scheduler_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) ();

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;

  // Environment side: producers and the transmitter.
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational rotate-priority encoder: first asserted request at or after rr_ptr, modulo N_REQ.
module uart_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest one to rr_ptr wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IDX_W'((32'(rr_ptr) + 32'(i)) % N_REQ);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between N_REQ byte producers.
// Define UART_TX_SCHED_LOCK_EN to keep a grant until the producer's last byte of a frame.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = UART_DATA_W,
  parameter int unsigned ACK_TIMEOUT = UART_ACK_TIMEOUT,
  localparam int unsigned IDX_W      = $clog2(N_REQ),
  localparam int unsigned TIMER_W    = $clog2(ACK_TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_scheduler_if.slave   bus,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 sched_busy,
  output logic                 err_timeout
);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic               start_q, start_d;
  logic               err_q, err_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic [N_REQ-1:0]   arb_req;
  logic [IDX_W-1:0]   arb_ptr;
  logic [IDX_W-1:0]   arb_grant;
  logic               arb_any;
  logic [DATA_W-1:0]  sel_data;

`ifdef UART_TX_SCHED_LOCK_EN
  logic               lock_q, lock_d;
`else
  logic               unused_last;
  assign unused_last = ^bus.req_last;
`endif

  // While a frame is locked only the owner (held in grant_q) may win.
  always_comb begin
    arb_req = bus.req_valid;
    arb_ptr = rr_ptr_q;
`ifdef UART_TX_SCHED_LOCK_EN
    if (lock_q) begin
      arb_req = bus.req_valid & (N_REQ'(1) << grant_q);
      arb_ptr = grant_q;
    end
`endif
  end

  uart_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arbiter (
    .req     (arb_req),
    .rr_ptr  (arb_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant == IDX_W'(i)) sel_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    timer_d  = timer_q;
    ready_d  = '0;
    start_d  = 1'b0;
    err_d    = 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
    lock_d   = lock_q;
`endif
    unique case (state_q)
      ARB: begin
        if (arb_any) begin
          grant_d            = arb_grant;
          data_d             = sel_data;
          ready_d[arb_grant] = 1'b1;
          start_d            = 1'b1;
          timer_d            = '0;
          state_d            = WAIT_ACK;
`ifdef UART_TX_SCHED_LOCK_EN
          if (bus.req_last[arb_grant]) begin
            rr_ptr_d = IDX_W'(rr_next(32'(arb_grant), N_REQ));
            lock_d   = 1'b0;
          end else begin
            lock_d   = 1'b1;
          end
`else
          rr_ptr_d = IDX_W'(rr_next(32'(arb_grant), N_REQ));
`endif
        end
      end
      WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
          // Byte is dropped; the producer already saw req_ready.
          err_d   = 1'b1;
          state_d = ARB;
`ifdef UART_TX_SCHED_LOCK_EN
          lock_d  = 1'b0;
`endif
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      ready_q  <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= '0;
`ifdef UART_TX_SCHED_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
`ifdef UART_TX_SCHED_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.tx_start  = start_q;
  assign bus.tx_data   = data_q;
  assign grant_id      = grant_q;
  assign sched_busy    = (state_q != ARB);
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed scoreboard bench for uart_tx_scheduler with producer and transmitter models.
module tb_uart_tx_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 512;

  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant_id;
  logic       sched_busy;
  logic       err_timeout;

  uart_tx_scheduler_if #(.N_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_scheduler #(
    .N_REQ       (NR),
    .DATA_W      (DW),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [8:0] src_q [NR][$];  // {last, data}
  exp_t sb[$];
  int tx_mode = 0;            // 0: normal transmitter, 1: never acknowledges
  int busy_len = 20;
  int ready0_cnt = 0;
  int to_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  logic to_pending = 1'b0;
  logic [7:0] held_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back({l, d});
  endtask

  task automatic expect_tx(input logic [1:0] g, input logic [7:0] d, input logic to);
    exp_t e;
    e.gid  = g;
    e.data = d;
    e.to   = to;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
      idle = (sb.size() == 0) && !sched_busy && !bus.tx_busy &&
             (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() == 0);
    end
    check({tag, "_done"}, 32'(idle), 32'd1);
  endtask

  // Producers: hold each byte until its req_ready pulse, then present the next one.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          bus.req_valid[i]          = 1'b1;
          bus.req_data[i*DW +: DW]  = src_q[i][0][7:0];
          bus.req_last[i]           = src_q[i][0][8];
        end else begin
          bus.req_valid[i]          = 1'b0;
          bus.req_data[i*DW +: DW]  = '0;
          bus.req_last[i]           = 1'b0;
        end
      end
    end
  end

  // Transmitter: busy rises 2 cycles after tx_start and stays up busy_len cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_start === 1'b1 && tx_mode == 0) begin
        repeat (2) @(posedge clk);
        #1;
        bus.tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Output monitor: pops the scoreboard on each tx_start.
  initial begin
    exp_t e;
    logic [3:0] oh;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        if (bus.tx_start) begin
          start_cnt++;
          check("start_while_busy", 32'(bus.tx_busy), 32'd0);
          check("start_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e  = sb.pop_front();
            oh = 4'b0001 << e.gid;
            check("grant_id", 32'(grant_id), 32'(e.gid));
            check("tx_data", 32'(bus.tx_data), 32'(e.data));
            check("req_ready_onehot", 32'(bus.req_ready), 32'(oh));
            start_cyc  = cyc;
            to_pending = e.to;
            held_data  = e.data;
          end
        end else begin
          check("ready_without_start", 32'(bus.req_ready), 32'd0);
          if (sched_busy) check("tx_data_hold", 32'(bus.tx_data), 32'(held_data));
        end
        if (bus.req_ready[0]) ready0_cnt++;
        if (err_timeout) begin
          to_cnt++;
          check("timeout_expected", 32'(to_pending), 32'd1);
          check("timeout_latency", 32'(cyc - start_cyc), 32'(TO));
          to_pending = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0_before;

    // Reset values
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_sched_busy", 32'(sched_busy), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // No requests: stays idle
    repeat (10) @(negedge clk);
    check("idle_sched_busy", 32'(sched_busy), 32'd0);
    check("idle_no_start", 32'(start_cnt), 32'd0);

    // All four requesters contending: 0,1,2,3,0,1
    busy_len = 20;
    load(0, 8'h10, 1'b1); load(0, 8'h14, 1'b1);
    load(1, 8'h11, 1'b1); load(1, 8'h15, 1'b1);
    load(2, 8'h12, 1'b1);
    load(3, 8'h13, 1'b1);
    expect_tx(2'd0, 8'h10, 1'b0);
    expect_tx(2'd1, 8'h11, 1'b0);
    expect_tx(2'd2, 8'h12, 1'b0);
    expect_tx(2'd3, 8'h13, 1'b0);
    expect_tx(2'd0, 8'h14, 1'b0);
    expect_tx(2'd1, 8'h15, 1'b0);
    wait_idle(2000, "all4");
    check("all4_starts", 32'(start_cnt), 32'd6);

    // Transmitter never acknowledges: timeout, then next request served
    tx_mode = 1;
    load(3, 8'h3C, 1'b1);
    expect_tx(2'd3, 8'h3C, 1'b1);
    wait_idle(2000, "timeout");
    check("timeout_count", 32'(to_cnt), 32'd1);
    tx_mode = 0;
    load(0, 8'h11, 1'b1);
    expect_tx(2'd0, 8'h11, 1'b0);
    wait_idle(2000, "after_timeout");
    check("timeout_count_after", 32'(to_cnt), 32'd1);

    // Reset during WAIT_DONE
    busy_len = 40;
    load(2, 8'h22, 1'b1);
    expect_tx(2'd2, 8'h22, 1'b0);
    n = 0;
    while (!(sched_busy && bus.tx_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait_done", 32'(sched_busy && bus.tx_busy), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd0);
    check("mid_rst_sched_busy", 32'(sched_busy), 32'd0);
    check("mid_rst_err_timeout", 32'(err_timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (bus.tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_drained", 32'(bus.tx_busy), 32'd0);
    // rr_ptr back at 0: requester 1 wins over 3
    busy_len = 20;
    load(1, 8'h31, 1'b1);
    load(3, 8'h33, 1'b1);
    expect_tx(2'd1, 8'h31, 1'b0);
    expect_tx(2'd3, 8'h33, 1'b0);
    wait_idle(2000, "post_reset");

    // Single byte from requester 0 with a long transmission
    busy_len = 1040;
    r0_before = ready0_cnt;
    load(0, 8'hA5, 1'b1);
    expect_tx(2'd0, 8'hA5, 1'b0);
    wait_idle(3000, "single");
    check("single_ready0_pulses", 32'(ready0_cnt - r0_before), 32'd1);
    check("single_back_to_arb", 32'(sched_busy), 32'd0);

    // Requester 1 sends a 3-byte frame while 0 and 2 contend (rr_ptr is 1 here)
    busy_len = 20;
    load(1, 8'hA1, 1'b0); load(1, 8'hA2, 1'b0); load(1, 8'hA3, 1'b1);
    load(0, 8'h0B, 1'b1);
    load(2, 8'h2B, 1'b1);
`ifdef UART_TX_SCHED_LOCK_EN
    expect_tx(2'd1, 8'hA1, 1'b0);
    expect_tx(2'd1, 8'hA2, 1'b0);
    expect_tx(2'd1, 8'hA3, 1'b0);
    expect_tx(2'd2, 8'h2B, 1'b0);
    expect_tx(2'd0, 8'h0B, 1'b0);
`else
    expect_tx(2'd1, 8'hA1, 1'b0);
    expect_tx(2'd2, 8'h2B, 1'b0);
    expect_tx(2'd0, 8'h0B, 1'b0);
    expect_tx(2'd1, 8'hA2, 1'b0);
    expect_tx(2'd1, 8'hA3, 1'b0);
`endif
    wait_idle(2000, "frame");
    check("total_starts", 32'(start_cnt), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
